// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (round-to-nearest-even, flush-to-zero).
// Latency: 3 cycles from input transfer to out_valid; throughput one result per cycle.
// Backpressure: all stages advance together when !out_valid | out_ready, otherwise every stage holds.
module fadd_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic             ovf,
  output logic             unf,
  output logic             inv
);

  // Significand layout: hidden bit, MW fraction bits, then guard/round/sticky.
  localparam int SW  = MW + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EW+1:0]        ONE  = {{(EW+1){1'b0}}, 1'b1};
  localparam logic signed [EW+1:0] EMAX = {2'b00, {EW{1'b1}}};

  logic w_en;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic            w_sa, w_sb;
  logic [EW-1:0]   w_ea, w_eb;
  logic [MW-1:0]   w_ma, w_mb, w_ma_f, w_mb_f;
  logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic            w_swap;
  logic            w_bs, w_ss;
  logic [EW-1:0]   w_be, w_se, w_d;
  logic [MW-1:0]   w_bm, w_sm;
  logic            w_s_zero, w_b_zero_big;
  logic [SW-1:0]   w_big_sig, w_pre, w_shf, w_sig_b;
  logic            w_stk;

  assign w_sa = x1[EW+MW];
  assign w_sb = x2[EW+MW] ^ sub;
  assign w_ea = x1[EW+MW-1:MW];
  assign w_eb = x2[EW+MW-1:MW];
  assign w_ma = x1[MW-1:0];
  assign w_mb = x2[MW-1:0];

  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_a_nan  = (&w_ea) &  (|w_ma);
  assign w_b_nan  = (&w_eb) &  (|w_mb);
  assign w_a_inf  = (&w_ea) & ~(|w_ma);
  assign w_b_inf  = (&w_eb) & ~(|w_mb);

  // Denormal inputs are treated as zero: drop their fraction before comparing.
  assign w_ma_f = w_a_zero ? '0 : w_ma;
  assign w_mb_f = w_b_zero ? '0 : w_mb;

  assign w_swap = {w_eb, w_mb_f} > {w_ea, w_ma_f};
  assign w_bs   = w_swap ? w_sb     : w_sa;
  assign w_ss   = w_swap ? w_sa     : w_sb;
  assign w_be   = w_swap ? w_eb     : w_ea;
  assign w_se   = w_swap ? w_ea     : w_eb;
  assign w_bm   = w_swap ? w_mb_f   : w_ma_f;
  assign w_sm   = w_swap ? w_ma_f   : w_mb_f;
  assign w_b_zero_big = w_swap ? w_b_zero : w_a_zero;
  assign w_s_zero     = w_swap ? w_a_zero : w_b_zero;

  assign w_d       = w_be - w_se;
  assign w_big_sig = {~w_b_zero_big, w_bm, 3'b000};
  assign w_pre     = {~w_s_zero, w_sm, 3'b000};
  assign w_shf     = w_pre >> w_d;
  // Everything shifted past the sticky position collapses into the sticky bit.
  assign w_stk     = |(w_pre & ~({SW{1'b1}} << w_d));
  assign w_sig_b   = {w_shf[SW-1:1], w_shf[0] | w_stk};

  logic            r1_vld, r1_sign, r1_eff_sub, r1_nan, r1_inf, r1_inf_s, r1_bz, r1_bz_s;
  logic [EW-1:0]   r1_exp;
  logic [SW-1:0]   r1_sig_a, r1_sig_b;

  // Stage 1 register: aligned significands plus special-case classification
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r1_vld <= 1'b0;
    end else if (w_en) begin
      r1_vld     <= in_valid;
      r1_sign    <= w_bs;
      r1_eff_sub <= w_bs ^ w_ss;
      r1_exp     <= w_be;
      r1_sig_a   <= w_big_sig;
      r1_sig_b   <= w_sig_b;
      r1_nan     <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
      r1_inf     <= w_a_inf | w_b_inf;
      r1_inf_s   <= w_a_inf ? w_sa : w_sb;
      r1_bz      <= w_a_zero & w_b_zero;
      r1_bz_s    <= w_sa & w_sb;
    end
  end

  // ---------------- Stage 2: add/subtract, LZC, normalise ----------------
  logic [SW:0]     w_sum;
  logic [LZW-1:0]  w_lzc;
  logic [SW-1:0]   w_norm;
  logic [EW+1:0]   w_e2;

  assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_a} - {1'b0, r1_sig_b})
                            : ({1'b0, r1_sig_a} + {1'b0, r1_sig_b});

  // Leading-zero count of the sum below the carry bit (SW when the sum is zero)
  always_comb begin
    w_lzc = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (w_sum[i]) w_lzc = LZW'(SW - 1 - i);
    end
  end

  assign w_norm = w_sum[SW] ? {w_sum[SW:2], w_sum[1] | w_sum[0]}
                            : (w_sum[SW-1:0] << w_lzc);
  assign w_e2   = w_sum[SW] ? ({2'b00, r1_exp} + ONE)
                            : ({2'b00, r1_exp} - {{(EW+2-LZW){1'b0}}, w_lzc});

  logic                  r2_vld, r2_sign, r2_zero, r2_nan, r2_inf, r2_inf_s, r2_bz, r2_bz_s;
  logic signed [EW+1:0]  r2_exp;
  logic [SW-1:0]         r2_sig;

  // Stage 2 register: normalised significand, signed exponent and carried-along classes
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r2_vld <= 1'b0;
    end else if (w_en) begin
      r2_vld   <= r1_vld;
      r2_sign  <= r1_sign;
      r2_exp   <= w_e2;
      r2_sig   <= w_norm;
      r2_zero  <= ~|w_sum;
      r2_nan   <= r1_nan;
      r2_inf   <= r1_inf;
      r2_inf_s <= r1_inf_s;
      r2_bz    <= r1_bz;
      r2_bz_s  <= r1_bz_s;
    end
  end

  // ---------------- Stage 3: round, special cases, pack ----------------
  logic                  w_rup, w_carry;
  logic [MW+1:0]         w_rnd;
  logic [MW-1:0]         w_mant;
  logic signed [EW+1:0]  w_e3;
  logic [EW+MW:0]        w_y;
  logic                  w_ovf, w_unf, w_inv;

  // Ties go to even: round up on guard when round/sticky is set or the LSB is odd.
  assign w_rup   = r2_sig[2] & (r2_sig[1] | r2_sig[0] | r2_sig[3]);
  assign w_rnd   = {1'b0, r2_sig[SW-1:3]} + {{(MW+1){1'b0}}, w_rup};
  assign w_carry = w_rnd[MW+1];
  assign w_mant  = w_carry ? w_rnd[MW:1] : w_rnd[MW-1:0];
  assign w_e3    = r2_exp + $signed({{(EW+1){1'b0}}, w_carry});

  // Result selection in special-case priority order; flags default low
  always_comb begin
    w_y   = {r2_sign, w_e3[EW-1:0], w_mant};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    if (r2_nan) begin
      w_y   = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      w_inv = 1'b1;
    end else if (r2_inf) begin
      w_y = {r2_inf_s, {EW{1'b1}}, {MW{1'b0}}};
    end else if (r2_bz) begin
      w_y = {r2_bz_s, {(EW+MW){1'b0}}};
    end else if (r2_zero) begin
      w_y = '0;
    end else if (r2_exp[EW+1] | ~|r2_exp) begin
      w_y   = {r2_sign, {(EW+MW){1'b0}}};
      w_unf = 1'b1;
    end else if (w_e3 >= EMAX) begin
      w_y   = {r2_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_ovf = 1'b1;
    end
  end

  logic            r3_vld, r3_ovf, r3_unf, r3_inv;
  logic [EW+MW:0]  r3_y;

  // Output register: result and flags, cleared on reset so a stalled reset shows zeros
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r3_vld <= 1'b0;
      r3_y   <= '0;
      r3_ovf <= 1'b0;
      r3_unf <= 1'b0;
      r3_inv <= 1'b0;
    end else if (w_en) begin
      r3_vld <= r2_vld;
      r3_y   <= w_y;
      r3_ovf <= w_ovf;
      r3_unf <= w_unf;
      r3_inv <= w_inv;
    end
  end

  assign w_en      = ~r3_vld | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r3_vld;
  assign y         = r3_y;
  assign ovf       = r3_ovf;
  assign unf       = r3_unf;
  assign inv       = r3_inv;

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: single precision instance plus a half-precision instance.
// Checks latency, rounding, signs, specials, backpressure ordering and mid-flight reset.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, out_ready, sub;
  logic [31:0] x1, x2;
  logic        in_ready, out_valid, ovf, unf, inv;
  logic [31:0] y;

  logic        h_in_valid, h_out_ready, h_sub;
  logic [15:0] h_x1, h_x2;
  logic        h_in_ready, h_out_valid, h_ovf, h_unf, h_inv;
  logic [15:0] h_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fadd_pipe u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .unf(unf), .inv(inv)
  );

  fadd_pipe #(.EW(5), .MW(10)) u_half (
    .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .x1(h_x1), .x2(h_x2), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .y(h_y), .ovf(h_ovf), .unf(h_unf), .inv(h_inv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One isolated operation with out_ready high: latency, result and {ovf,unf,inv}
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] ey, input logic [2:0] ef);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; x1 = a; x2 = b; sub = s;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'd3);
    chk({tag, ".y"}, 64'(y), 64'(ey));
    chk({tag, ".flags"}, 64'({ovf, unf, inv}), 64'(ef));
  endtask

  logic [31:0] bp_a [6];
  logic [31:0] bp_b [6];
  logic [31:0] bp_y [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, recv, seen, lat;
    bit  acc_in;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; x1 = '0; x2 = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_sub = 1'b0; h_x1 = '0; h_x2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.y", 64'(y), 64'd0);
    chk("rst.flags", 64'({ovf, unf, inv}), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.h_out_valid", 64'(h_out_valid), 64'd0);
    rstn = 1'b1;

    // Basic function and latency
    run_one("add_1_1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    run_one("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
    // Rounding
    run_one("rne_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run_one("rne_above", 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000);
    run_one("rne_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    // Cancellation and zero signs
    run_one("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    run_one("negzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    run_one("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b010);
    // Specials
    run_one("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    run_one("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001);
    run_one("inf_p_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    run_one("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);

    // Backpressure: six back-to-back ops, out_ready low for cycles 4..8
    bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3F800000; bp_y[0] = 32'h40000000;
    bp_a[1] = 32'h40000000; bp_b[1] = 32'h3F800000; bp_y[1] = 32'h40400000;
    bp_a[2] = 32'h40400000; bp_b[2] = 32'h3F800000; bp_y[2] = 32'h40800000;
    bp_a[3] = 32'h40800000; bp_b[3] = 32'h3F800000; bp_y[3] = 32'h40A00000;
    bp_a[4] = 32'h40A00000; bp_b[4] = 32'h3F800000; bp_y[4] = 32'h40C00000;
    bp_a[5] = 32'h40C00000; bp_b[5] = 32'h40000000; bp_y[5] = 32'h41000000;
    sent = 0; recv = 0; acc_in = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(posedge clk);
      if (acc_in) sent++;
      #1;
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 6);
      sub       = 1'b0;
      if (sent < 6) begin
        x1 = bp_a[sent];
        x2 = bp_b[sent];
      end
      @(negedge clk);
      acc_in = in_valid && in_ready;
      if (out_valid && !out_ready) chk("bp.in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid) begin
        chk($sformatf("bp.y%0d", recv), 64'(y), 64'(bp_y[recv]));
        if (out_ready) recv++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.received", 64'(recv), 64'd6);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp.no_duplicates", 64'(seen), 64'd0);

    // Reset with two operations in flight
    @(posedge clk); #1;
    in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h3F800000; sub = 1'b0;
    @(posedge clk); #1;
    x1 = 32'h40000000; x2 = 32'h3F800000;
    @(posedge clk); #1;
    in_valid = 1'b0; rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.y", 64'(y), 64'd0);
    chk("midrst.flags", 64'({ovf, unf, inv}), 64'd0);
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst.discarded", 64'(seen), 64'd0);
    run_one("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);

    // Half-precision instance: 1.0 + 1.0
    @(posedge clk); #1;
    h_in_valid = 1'b1; h_x1 = 16'h3C00; h_x2 = 16'h3C00; h_sub = 1'b0;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (h_out_valid) begin
        lat = k;
        break;
      end
    end
    chk("half.latency", 64'(lat), 64'd3);
    chk("half.y", 64'(h_y), 64'h4000);
    chk("half.flags", 64'({h_ovf, h_unf, h_inv}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor. Successor to the single-cycle combinational fadd.
- Adds: configurable exponent/mantissa width, 3-stage pipeline with valid/ready flow control, a subtract mode, round-to-nearest-even, and Inf/NaN/overflow handling with status flags.
- Sits between the FPU operand-issue logic and the writeback arbiter.

Parameters:
- EW, 8, exponent width in bits.
- MW, 23, stored mantissa width in bits; word width W = 1+EW+MW.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- x1  in  W  operand A.
- x2  in  W  operand B.
- sub  in  1  0: y=x1+x2; 1: y=x1-x2 (x2 sign inverted at capture).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  W  result.
- ovf  out  1  result overflowed to ±Inf.
- unf  out  1  nonzero exact result flushed to ±0.
- inv  out  1  invalid operation (NaN input, or Inf−Inf).

Behaviour:
- Reset: rstn sampled low on a clk edge clears all stage valid bits. out_valid=0, y=0, ovf=unf=inv=0 on the following cycle. Reset wins over any concurrent handshake; in-flight operations are discarded, not completed.
- Handshake: en = !out_valid | out_ready; in_ready = en (combinational).
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - When en=1, all three stages advance together; a stage whose upstream is empty loads a bubble (valid=0). Bubbles are not collapsed.
  - When en=0, all stage registers hold.
  - y and flags stay stable while out_valid & !out_ready.
- Latency: exactly 3 cycles from input transfer to out_valid with out_ready held high. Throughput: 1 result per cycle. Results are delivered in input order; none are lost or duplicated.
- Stage 1:
  - Unpack; apply sub.
  - Exponent field 0 means zero (denormal inputs flushed, sign kept).
  - Swap so operand A has the larger magnitude by {exp, mant}.
  - Shift B's significand right by the exponent difference, keeping guard, round and a sticky bit (OR of all bits shifted out). A shift ≥ MW+3 leaves only sticky.
  - Classify specials.
- Stage 2:
  - Effective add or subtract of the (MW+4)-bit significands.
  - Leading-zero count, then normalise: right 1 on carry-out, else left by LZC.
  - Exponent adjusted in EW+2 signed bits.
- Stage 3:
  - Round to nearest, ties to even, using G/R/S.
  - Mantissa carry from rounding increments the exponent.
  - Pack the result.
- Special cases, in priority order:
  1. Any NaN input, or Inf + (−Inf) after sub: y = canonical qNaN {0, all-ones exp, 1, zeros}; inv=1.
  2. Otherwise any Inf input: y = that Inf with its sign.
  3. Exact zero result from nonzero operands: y = +0.
  4. Both operands zero: sign = AND of signs.
- Overflow: rounded exponent ≥ 2^EW−1 gives y = ±Inf, ovf=1.
- Underflow: normalised exponent ≤ 0 gives y = ±0 (result sign), unf=1.
- Flags are 0 whenever the corresponding condition does not hold. Flags travel with their result.

Test Plan:
- Latency: x1=0x3F800000, x2=0x3F800000, sub=0, out_ready=1 → y=0x40000000, out_valid exactly 3 cycles after the accept, all flags 0. Also x1=0x40400000, x2=0x3F800000, sub=1 → y=0x40000000.
- Rounding: 0x3F800000+0x33800000 (tie) → 0x3F800000. 0x3F800000+0x33C00000 → 0x3F800001. 0x3F800001+0x33800000 (tie, odd) → 0x3F800002.
- Cancellation/sign: 0x3F800000−0x3F800000 → 0x00000000. 0x80000000+0x80000000 → 0x80000000. 0x00800000−0x00C00000 → 0x80000000 with unf=1.
- Specials: 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, ovf=1. 0x7F800000+0xFF800000 → 0x7FC00000, inv=1. 0x7F800000+0x3F800000 → 0x7F800000, flags 0.
- Backpressure: stream 6 back-to-back ops while holding out_ready=0 for cycles 4–8 → in_ready low whenever out_valid & !out_ready; all 6 results emerge in order, unchanged, each transferred once.
- Reset mid-flight: 2 ops in the pipe, rstn=0 for one cycle → next cycle out_valid=0, y=0; the ops are never emitted; a new op after reset appears 3 cycles after its accept. Repeat with EW=5, MW=10: 0x3C00+0x3C00 → 0x4000.
